// File: rtl/cdc_hs_src.sv
// rtl/cdc_hs_src.sv - source half of a toggle (2-phase) req/ack CDC handshake
// Optional ack-wait timeout is enabled by defining CDC_HS_TIMEOUT_EN.
module cdc_hs_src #(
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              req_tgl,
    output logic [DATA_W-1:0] xfer_data,
    input  logic              ack_sync,
    output logic              busy,
    output logic [7:0]        xfer_cnt,
    output logic              timeout_err
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   ack_match;
    logic   accept;

    // The far side has caught up whenever its returned toggle equals ours.
    assign ack_match = (ack_sync == req_tgl);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept)    state_nxt = WAIT_ACK;
            WAIT_ACK: if (ack_match) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE:     in_ready = ack_match;
            WAIT_ACK: busy     = 1'b1;
            default: begin
                in_ready = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    // xfer_data and req_tgl only move on an accept, so both stay frozen while busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_tgl   <= 1'b0;
            xfer_data <= '0;
            xfer_cnt  <= 8'd0;
        end else begin
            if (accept) begin
                xfer_data <= in_data;
                req_tgl   <= ~req_tgl;
            end
            if (busy && ack_match) begin
                xfer_cnt <= xfer_cnt + 8'd1;
            end
        end
    end

`ifdef CDC_HS_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] WAIT_MAX = '1;
    localparam logic [TIMEOUT_W-1:0] WAIT_PRE = WAIT_MAX - 1'b1;

    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 timeout_q;

    // Saturating wait counter; the flag is raised on the edge it reaches all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if (busy && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_PRE) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
